// File: rtl/target_picker.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | target_picker: rejection-samples a 16-bit random value into 0..9999 and     |
// | reports it in binary and 4-digit BCD.                        Revision 1.0   |
// +-----------------------------------------------------------------------------+
module target_picker #(
    parameter int unsigned REJECT_LIMIT = 60000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] random_number,
    input  logic        start,
    input  logic        ack,
    output logic        busy,
    output logic        valid,
    output logic [13:0] answer_bin,
    output logic [15:0] answer_bcd,
    output logic [7:0]  reject_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAMPLE  = 3'd1,
        S_REDUCE  = 3'd2,
        S_CONVERT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [15:0] C_REJECT = 16'(REJECT_LIMIT);
    localparam logic [15:0] C_TEN_K  = 16'd10000;
    localparam logic [3:0]  C_LAST   = 4'd13;

    state_t      state_q, state_d;
    logic [15:0] work_q, work_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  step_q, step_d;
    logic [7:0]  rc_q, rc_d;
    logic [13:0] ans_bin_q, ans_bin_d;
    logic [15:0] ans_bcd_q, ans_bcd_d;

    logic [15:0] w_adj;
    logic [15:0] w_shift;
    logic [3:0]  w_idx;

    // Double-dabble step: correct every digit >= 5, then shift in the next binary bit.
    always_comb begin
        w_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (w_adj[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = w_adj[4*i +: 4] + 4'd3;
            end
        end
        w_idx   = C_LAST - step_q;
        w_shift = {w_adj[14:0], work_q[w_idx]};
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        bcd_d     = bcd_q;
        step_d    = step_q;
        rc_d      = rc_q;
        ans_bin_d = ans_bin_q;
        ans_bcd_d = ans_bcd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SAMPLE;
                    rc_d    = 8'd0;
                end
            end
            S_SAMPLE: begin
                if (random_number >= C_REJECT) begin
                    if (rc_q != 8'hFF) begin
                        rc_d = rc_q + 8'd1;
                    end
                end else begin
                    work_d  = random_number;
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (work_q >= C_TEN_K) begin
                    work_d = work_q - C_TEN_K;
                end else begin
                    step_d  = 4'd0;
                    bcd_d   = 16'd0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d  = w_shift;
                step_d = step_q + 4'd1;
                if (step_q == C_LAST) begin
                    ans_bin_d = work_q[13:0];
                    ans_bcd_d = w_shift;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            work_q    <= 16'd0;
            bcd_q     <= 16'd0;
            step_q    <= 4'd0;
            rc_q      <= 8'd0;
            ans_bin_q <= 14'd0;
            ans_bcd_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            bcd_q     <= bcd_d;
            step_q    <= step_d;
            rc_q      <= rc_d;
            ans_bin_q <= ans_bin_d;
            ans_bcd_q <= ans_bcd_d;
        end
    end

    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign valid        = (state_q == S_DONE);
    assign answer_bin   = ans_bin_q;
    assign answer_bcd   = ans_bcd_q;
    assign reject_count = rc_q;

endmodule
`default_nettype wire

// File: tb/tb_target_picker.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_target_picker: randomized self-checking bench for target_picker.         |
// |                                                              Revision 1.0   |
// +-----------------------------------------------------------------------------+
module tb_target_picker;
    localparam int LIMIT = 60000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] random_number = 16'd0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic        busy, valid;
    logic [13:0] answer_bin;
    logic [15:0] answer_bcd;
    logic [7:0]  reject_count;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] seq[$];

    target_picker #(.REJECT_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset), .random_number(random_number),
        .start(start), .ack(ack), .busy(busy), .valid(valid),
        .answer_bin(answer_bin), .answer_bcd(answer_bcd), .reject_count(reject_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected result from the sample stream: first sample below LIMIT, reduced mod 10000.
    function automatic void model(output int lat, output logic [13:0] bin,
                                  output logic [15:0] bcd, output logic [7:0] rc);
        int r, v, b;
        r = 0;
        while (int'(seq[r]) >= LIMIT) r++;
        v   = int'(seq[r]);
        b   = v % 10000;
        bin = 14'(b);
        bcd = {4'(b / 1000), 4'((b / 100) % 10), 4'((b / 10) % 10), 4'(b % 10)};
        lat = 17 + r + v / 10000;
        rc  = (r > 255) ? 8'd255 : 8'(r);
    endfunction

    // Drives one request from IDLE, presenting seq[k] before edge k+2; returns at DONE.
    task automatic run_op(input int poke_start, input int poke_ack, output int lat);
        start = 1'b1;
        random_number = 16'($urandom);
        lat = 0;
        for (int e = 1; e <= 2000; e++) begin
            tick();
            start = (e == poke_start);
            ack   = (e == poke_ack);
            random_number = (e - 1 < seq.size()) ? seq[e-1] : 16'($urandom);
            if (valid) begin
                lat = e;
                break;
            end
        end
        start = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        ack   = 1'b1;
        random_number = 16'd5;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        tests_run += 5;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (answer_bin !== 14'd0) begin tests_failed++; $display("FAIL reset_bin: got %0d expected 0", answer_bin); end
        if (answer_bcd !== 16'h0000) begin tests_failed++; $display("FAIL reset_bcd: got %h expected 0000", answer_bcd); end
        if (reject_count !== 8'd0) begin tests_failed++; $display("FAIL reset_rc: got %0d expected 0", reject_count); end
    endtask

    task automatic test_nominal();
        int lat;
        seq = '{16'h9999};
        run_op(0, 0, lat);
        tests_run += 5;
        if (lat != 20) begin tests_failed++; $display("FAIL nominal_latency: got %0d expected 20", lat); end
        if (answer_bin !== 14'd9321) begin tests_failed++; $display("FAIL nominal_bin: got %0d expected 9321", answer_bin); end
        if (answer_bcd !== 16'h9321) begin tests_failed++; $display("FAIL nominal_bcd: got %h expected 9321", answer_bcd); end
        if (reject_count !== 8'd0) begin tests_failed++; $display("FAIL nominal_rc: got %0d expected 0", reject_count); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL nominal_busy_done: got %b expected 0", busy); end
        do_ack();
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL nominal_ack: valid got %b expected 0", valid); end
    endtask

    task automatic test_reject();
        int lat;
        seq = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd5};
        run_op(0, 0, lat);
        tests_run += 3;
        if (lat != 20) begin tests_failed++; $display("FAIL reject_latency: got %0d expected 20", lat); end
        if (answer_bcd !== 16'h0005) begin tests_failed++; $display("FAIL reject_bcd: got %h expected 0005", answer_bcd); end
        if (reject_count !== 8'd3) begin tests_failed++; $display("FAIL reject_rc: got %0d expected 3", reject_count); end
        do_ack();
    endtask

    task automatic test_boundary();
        int lat, elat;
        logic [13:0] ebin;
        logic [15:0] ebcd;
        logic [7:0]  erc;
        logic [15:0] cases [4] = '{16'd59999, 16'd10000, 16'd60000, 16'd0};
        for (int c = 0; c < 4; c++) begin
            seq = '{cases[c]};
            if (c == 2) seq.push_back(16'd9999);
            model(elat, ebin, ebcd, erc);
            run_op(0, 0, lat);
            tests_run += 3;
            if (lat != elat) begin tests_failed++; $display("FAIL boundary_latency[%0d]: got %0d expected %0d", c, lat, elat); end
            if (answer_bcd !== ebcd) begin tests_failed++; $display("FAIL boundary_bcd[%0d]: got %h expected %h", c, answer_bcd, ebcd); end
            if (answer_bin !== ebin) begin tests_failed++; $display("FAIL boundary_bin[%0d]: got %0d expected %0d", c, answer_bin, ebin); end
            do_ack();
        end
        seq = {};
        for (int k = 0; k < 300; k++) seq.push_back(16'hFFFF);
        seq.push_back(16'd1234);
        run_op(0, 0, lat);
        tests_run += 3;
        if (reject_count !== 8'd255) begin tests_failed++; $display("FAIL saturate_rc: got %0d expected 255", reject_count); end
        if (lat != 317) begin tests_failed++; $display("FAIL saturate_latency: got %0d expected 317", lat); end
        if (answer_bcd !== 16'h1234) begin tests_failed++; $display("FAIL saturate_bcd: got %h expected 1234", answer_bcd); end
        do_ack();
    endtask

    task automatic test_handshake();
        int lat, unstable;
        logic [13:0] hbin;
        logic [15:0] hbcd;
        seq = '{16'd4242};
        run_op(5, 8, lat);
        tests_run += 2;
        if (lat != 17) begin tests_failed++; $display("FAIL busy_inputs_latency: got %0d expected 17", lat); end
        if (answer_bcd !== 16'h4242) begin tests_failed++; $display("FAIL busy_inputs_bcd: got %h expected 4242", answer_bcd); end
        hbin = answer_bin;
        hbcd = answer_bcd;
        unstable = 0;
        for (int k = 0; k < 10; k++) begin
            random_number = 16'($urandom);
            tick();
            if (valid !== 1'b1 || answer_bin !== hbin || answer_bcd !== hbcd) unstable++;
        end
        tests_run++;
        if (unstable != 0) begin tests_failed++; $display("FAIL done_hold: got %0d unstable cycles expected 0", unstable); end
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        tests_run += 2;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL start_ack_valid: got %b expected 0", valid); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL start_ack_busy: got %b expected 0", busy); end
        for (int k = 0; k < 5; k++) tick();
        tests_run += 2;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL no_restart: busy got %b expected 0", busy); end
        if (answer_bcd !== 16'h4242) begin tests_failed++; $display("FAIL idle_hold_bcd: got %h expected 4242", answer_bcd); end
    endtask

    task automatic test_midreset();
        int lat, seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        random_number = 16'd7;
        for (int k = 0; k < 5; k++) tick();
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run += 3;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_valid: got %b expected 0", valid); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        if (answer_bcd !== 16'h0000) begin tests_failed++; $display("FAIL midreset_bcd: got %h expected 0000", answer_bcd); end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valid || busy) seen++;
        end
        tests_run++;
        if (seen != 0) begin tests_failed++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen); end
        seq = '{16'h1234};
        run_op(0, 0, lat);
        tests_run += 3;
        if (answer_bcd !== 16'h4660) begin tests_failed++; $display("FAIL after_reset_bcd: got %h expected 4660", answer_bcd); end
        if (answer_bin !== 14'd4660) begin tests_failed++; $display("FAIL after_reset_bin: got %0d expected 4660", answer_bin); end
        if (lat != 17) begin tests_failed++; $display("FAIL after_reset_latency: got %0d expected 17", lat); end
        do_ack();
    endtask

    task automatic test_random();
        int lat, elat, nrej;
        logic [13:0] ebin;
        logic [15:0] ebcd;
        logic [7:0]  erc;
        for (int t = 0; t < 40; t++) begin
            seq = {};
            nrej = int'($urandom_range(0, 4));
            for (int k = 0; k < nrej; k++) seq.push_back(16'($urandom_range(LIMIT, 65535)));
            seq.push_back(16'($urandom_range(0, LIMIT - 1)));
            model(elat, ebin, ebcd, erc);
            run_op(0, 0, lat);
            tests_run += 4;
            if (lat != elat) begin tests_failed++; $display("FAIL random_latency[%0d]: got %0d expected %0d", t, lat, elat); end
            if (answer_bin !== ebin) begin tests_failed++; $display("FAIL random_bin[%0d]: got %0d expected %0d", t, answer_bin, ebin); end
            if (answer_bcd !== ebcd) begin tests_failed++; $display("FAIL random_bcd[%0d]: got %h expected %h", t, answer_bcd, ebcd); end
            if (reject_count !== erc) begin tests_failed++; $display("FAIL random_rc[%0d]: got %0d expected %0d", t, reject_count, erc); end
            do_ack();
            tests_run++;
            if (valid !== 1'b0) begin tests_failed++; $display("FAIL random_ack[%0d]: valid got %b expected 0", t, valid); end
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_nominal();
        test_reject();
        test_boundary();
        test_handshake();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/target_picker.md
TARGET_PICKER -- requirements
Module: target_picker

Interface
REQ-001 The block SHALL have parameter REJECT_LIMIT, default 60000: raw samples >= this value are discarded; legal values are 10000, 20000, ... 60000.
REQ-002 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port random_number  input  16  free-running pseudo-random value from the LFSR stage; it changes every clock.
REQ-005 The block SHALL have port start  input  1  request a new target; honoured only in IDLE.
REQ-006 The block SHALL have port ack  input  1  consumer has taken the result; honoured only in DONE.
REQ-007 The block SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-008 The block SHALL have port valid  output  1  high only in DONE.
REQ-009 The block SHALL have port answer_bin  output  14  target value, 0..9999, binary.
REQ-010 The block SHALL have port answer_bcd  output  16  the same target as 4 BCD digits, thousands digit in [15:12].
REQ-011 The block SHALL have port reject_count  output  8  raw samples discarded for the current target, saturating at 255.

Function
REQ-012 The FSM SHALL have exactly five states: IDLE, SAMPLE, REDUCE, CONVERT, DONE.
REQ-013 In IDLE, start=1 SHALL move to SAMPLE on that edge and clear reject_count to 0; start=0 SHALL hold IDLE.
REQ-014 In SAMPLE, random_number >= REJECT_LIMIT SHALL stay in SAMPLE and increment reject_count, saturating at 255; otherwise random_number SHALL be latched into a 16-bit work register and the FSM SHALL go to REDUCE.
REQ-015 In REDUCE, work >= 10000 SHALL subtract 10000 from work, one subtraction per cycle; otherwise the FSM SHALL go to CONVERT with step counter = 0 and BCD scratch = 0.
REQ-016 The worst case in REDUCE SHALL be 5 subtraction cycles (input 59999) plus 1 exit cycle.
REQ-017 CONVERT SHALL perform shift-add-3 (double dabble) on work[13:0], MSB first, one bit per cycle, for exactly 14 cycles.
REQ-018 In each CONVERT cycle, every BCD digit >= 5 SHALL have 3 added to it before the shift.
REQ-019 The 14th CONVERT cycle SHALL go to DONE.
REQ-020 On entry to DONE, answer_bin SHALL be loaded with work[13:0] and answer_bcd with the BCD result; both SHALL stay stable until the next entry to DONE.
REQ-021 In DONE, valid SHALL be 1 and ack=1 SHALL return the FSM to IDLE, so valid is 0 after that edge.
REQ-022 start SHALL be ignored outside IDLE, including start and ack asserted together in DONE (ack wins; there is no automatic restart).
REQ-023 ack SHALL be ignored outside DONE.
REQ-024 Latency SHALL be 17 + r + n rising edges, counting the edge that samples start as edge 1, where r = rejected samples and n = subtractions; valid is visible after the last of these edges.
REQ-025 answer_bin and answer_bcd SHALL always encode the same value, and every BCD digit SHALL be <= 9.
REQ-026 There SHALL be no upper bound on consecutive rejections; the FSM stays in SAMPLE while random_number >= REJECT_LIMIT.

Reset
REQ-027 reset=1 on a rising edge SHALL force IDLE and clear valid, busy, answer_bin, answer_bcd, reject_count, work, BCD scratch and step counter to 0, overriding all other inputs.
REQ-028 Reset asserted mid-operation (SAMPLE, REDUCE, CONVERT or DONE) SHALL abort the operation with no valid pulse; the first start after reset SHALL begin a fresh operation.

Verification
REQ-029 Reset check: hold reset 2 cycles -> valid=0, busy=0, answer_bin=0, answer_bcd=16'h0000, reject_count=0.
REQ-030 Nominal case: random_number=16'h9999 (39321) held, start pulse -> valid on edge 20, answer_bin=9321, answer_bcd=16'h9321, reject_count=0.
REQ-031 Rejection case: random_number=65535 for 3 cycles then 5 -> reject_count=3, answer_bcd=16'h0005, valid on edge 20 (r=3, n=0).
REQ-032 Boundary case: random_number=59999 -> answer_bcd=16'h9999 after 5 subtractions; random_number=10000 -> answer_bcd=16'h0000.
REQ-033 Handshake case: hold ack=0 for 10 cycles in DONE -> valid and outputs stable; assert start and ack together -> IDLE with no new operation; start while busy -> ignored.
REQ-034 Mid-operation reset: reset pulsed during CONVERT -> IDLE and valid=0 next edge; next start with 16'h1234 (4660) -> answer_bcd=16'h4660.
